sig_stream_tx: RTL and testbench

//   Parametrised signature/message streamer: holds a constant message of MSG_BITS bits and

---
 rtl/sig_stream_pkg.sv | 22 ++
 rtl/sig_stream_tx_if.sv | 14 +
 rtl/sig_stream_tx_col_parity.sv | 23 ++
 rtl/sig_stream_tx.sv | 137 +++++++++++++
 tb/tb_sig_stream_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sig_stream_pkg.sv
// Shared types and constants for the signature streamer.
//   state_t          FSM states (IDLE, SEND, PARITY)
//   SIG_DEFAULT_MSG  320-bit ASCII banner, first character in the top byte
//   sig_ptr_w()      beat-pointer width for a given beat count (minimum 1)
package sig_stream_pkg;

  typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;

  localparam int SIG_DEFAULT_BITS = 320;
  localparam logic [SIG_DEFAULT_BITS-1:0] SIG_DEFAULT_MSG =
    "sig_stream_tx banner: hello from rtl!!!!";

  // ceil(log2(nbeats)), never less than 1 so a single-beat message still has a pointer
  function automatic int sig_ptr_w(input int nbeats);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << w) < nbeats) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/sig_stream_tx_if.sv
// Beat stream between the streamer and its sink.
//   out_valid  beat available          (master -> slave)
//   out_ready  sink accepts beat       (slave  -> master)
//   out_data   LANES-bit beat, bit LANES-1 is the earlier message bit
//   out_last   final beat of the frame
interface sig_stream_tx_if #(parameter int LANES = 1);
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/sig_stream_tx_col_parity.sv
// sig_col_parity: column-parity accumulator, one flop per lane.
//   clk, reset  clock / async active-high reset
//   clr         zero the accumulator (wins over en)
//   en          fold din into the accumulator
//   din         LANES-bit beat
//   par         running XOR of every folded beat
module sig_col_parity #(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] par
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    always_ff @(posedge clk or posedge reset)
      if (reset)   par[i] <= 1'b0;
      else if (clr) par[i] <= 1'b0;
      else if (en)  par[i] <= par[i] ^ din[i];
  end
endmodule

// File: rtl/sig_stream_tx.sv
// sig_stream_tx: streams the constant MSG MSB-first, LANES bits per beat.
//   clk, reset      clock / async active-high reset
//   start           begin a frame (IDLE only)
//   loop            at frame end: 1 = restart immediately, 0 = stop and pulse done
//   abort           drop the frame, back to IDLE (wins over start)
//   tx (master)     out_valid/out_ready/out_data/out_last beat stream
//   busy            not IDLE
//   done            one-cycle pulse after the last beat of a non-looping frame
// Build option: define SIG_STREAM_PARITY_EN to append one column-parity beat per frame.
module sig_stream_tx
  import sig_stream_pkg::*;
#(
  parameter int                  MSG_BITS = SIG_DEFAULT_BITS,
  parameter int                  LANES    = 1,
  parameter logic [MSG_BITS-1:0] MSG      = SIG_DEFAULT_MSG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          loop,
  input  logic          abort,
  sig_stream_tx_if.master tx,
  output logic          busy,
  output logic          done
);
  localparam int NBEATS = MSG_BITS / LANES;
  localparam int PTR_W  = sig_ptr_w(NBEATS);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NBEATS - 1);

  if (MSG_BITS % LANES != 0) begin : g_bad_cfg
    $error("sig_stream_tx: MSG_BITS must be a multiple of LANES");
  end

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             done_nxt;
  logic             vld, xfer;
  logic [LANES-1:0] msg_beat;

  assign vld      = (state != IDLE);
  assign xfer     = vld & tx.out_ready;
  assign msg_beat = MSG[int'(ptr)*LANES +: LANES];

`ifdef SIG_STREAM_PARITY_EN
  logic [LANES-1:0] par;

  // Cleared whenever a fresh frame can begin: in IDLE, on abort, and on loop wrap.
  sig_col_parity #(.LANES(LANES)) u_par (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) | abort | ((state == PARITY) & xfer)),
    .en    ((state == SEND) & xfer),
    .din   (msg_beat),
    .par   (par)
  );
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr   <= PTR_MAX;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= done_nxt;
    end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start && !abort) state_nxt = SEND;
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
          ptr_nxt   = PTR_MAX;
        end else if (xfer) begin
          if (ptr != '0) ptr_nxt = ptr - 1'b1;
          else begin
            ptr_nxt = PTR_MAX;
`ifdef SIG_STREAM_PARITY_EN
            state_nxt = PARITY;
`else
            if (!loop) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
`endif
          end
        end
      end
`ifdef SIG_STREAM_PARITY_EN
      PARITY: begin
        if (abort) state_nxt = IDLE;
        else if (xfer) begin
          if (loop) state_nxt = SEND;
          else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = PTR_MAX;
      end
    endcase
  end

  // Beat output: zero outside a frame so the link idles low.
  always_comb begin
    tx.out_data = '0;
    tx.out_last = 1'b0;
    case (state)
      SEND: begin
        tx.out_data = msg_beat;
`ifndef SIG_STREAM_PARITY_EN
        tx.out_last = (ptr == '0);
`endif
      end
`ifdef SIG_STREAM_PARITY_EN
      PARITY: begin
        tx.out_data = par;
        tx.out_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign tx.out_valid = vld;
  assign busy         = vld;

endmodule

// File: tb/tb_sig_stream_tx.sv
module tb_sig_stream_tx;
  localparam int LANES    = 4;
  localparam int MSG_BITS = 16;
  localparam logic [MSG_BITS-1:0] MSG = 16'h1234;
  localparam int NBEATS = MSG_BITS / LANES;
`ifdef SIG_STREAM_PARITY_EN
  localparam int FRAME = NBEATS + 1;
`else
  localparam int FRAME = NBEATS;
`endif
  localparam int OW = LANES + 4;

  logic clk = 1'b0;
  logic reset, start, loop, abort, busy, done;

  sig_stream_tx_if #(.LANES(LANES)) bus();

  sig_stream_tx #(.MSG_BITS(MSG_BITS), .LANES(LANES), .MSG(MSG)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .loop  (loop),
    .abort (abort),
    .tx    (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: the frame as a list of beats, and where in it we are.
  logic [LANES-1:0] beats [FRAME];
  bit m_active;
  int m_idx;
  bit m_done;

  function automatic void build_beats();
    logic [MSG_BITS-1:0] m;
    logic [LANES-1:0] x;
    m = MSG;
    x = '0;
    for (int i = 0; i < NBEATS; i++) begin
      beats[i] = LANES'(m >> (MSG_BITS - (i + 1) * LANES));
      x ^= beats[i];
    end
    if (FRAME > NBEATS) beats[FRAME-1] = x;
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.out_valid, bus.out_last, busy, done, bus.out_data};
  endfunction

  function automatic logic [OW-1:0] exp_obs();
    logic [LANES-1:0] d;
    d = m_active ? beats[m_idx] : '0;
    return {m_active, m_active && (m_idx == FRAME - 1), m_active, m_done, d};
  endfunction

  function automatic void model_clear();
    m_active = 0; m_idx = 0; m_done = 0;
  endfunction

  // Apply one cycle of inputs at the negedge, advance the model at the posedge.
  task automatic step(input bit s, input bit l, input bit a, input bit r);
    start = s; loop = l; abort = a; bus.out_ready = r;
    @(posedge clk);
    m_done = 0;
    if (a) begin
      m_active = 0; m_idx = 0;
    end else if (!m_active) begin
      if (s) begin m_active = 1; m_idx = 0; end
    end else if (r) begin
      if (m_idx == FRAME - 1) begin
        m_idx = 0;
        if (!l) begin m_active = 0; m_done = 1; end
      end else m_idx++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; start = 0; loop = 0; abort = 0; bus.out_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=%h", obs(), {OW{1'b0}});
    end
    reset = 0;
    @(negedge clk);
    n_vec++;
    if (obs() !== exp_obs()) begin
      n_err++; $display("FAIL reset_release got=%h want=%h", obs(), exp_obs());
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < FRAME + 3; c++) begin
      step(c == 0, 0, 0, 1);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL single c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
      if (c == 0) begin
        n_vec++;
        if (bus.out_data !== 4'h1) begin
          n_err++; $display("FAIL single_first_beat got=%h want=1", bus.out_data);
        end
      end
    end
  endtask

  task automatic test_stall();
    // ready alternates 1/0; a stray start mid-frame must be ignored
    for (int c = 0; c < 2 * FRAME + 6; c++) begin
      step(c == 0 || c == 3, 0, 0, c[0]);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL stall c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_loop();
    for (int c = 0; c < 3 * FRAME + 4; c++) begin
      step(c == 0, c < 2 * FRAME + 2, 0, 1);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL loop c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_abort();
    // start+abort together in IDLE, then abort after the 2nd beat, then a clean restart
    for (int c = 0; c < FRAME + 10; c++) begin
      step(c == 0 || c == 1 || c == 5, 0, c == 0 || c == 3, 1);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL abort c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    #2 reset = 1;
    model_clear();
    #1;
    n_vec++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL async_reset got=%h want=%h", obs(), {OW{1'b0}});
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    for (int c = 0; c < FRAME + 2; c++) begin
      step(c == 0, 0, 0, 1);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL after_reset c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      n_vec++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL random c=%0d got=%h want=%h", c, obs(), exp_obs());
      end
    end
  endtask

  initial begin
    build_beats();
    test_reset();
    test_single();
    test_stall();
    test_loop();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
